// File: rtl/vga_v_timing.sv
// vga_v_timing
//   Parametrised vertical timing generator. Advances one line per
//   end-of-line strobe from the horizontal counter, tracks the vertical
//   region (active, front porch, sync, back porch) with a small FSM and
//   produces registered sync/blanking/frame signals for the renderer.
//
// Ports
//   clk_25Mhz      in   pixel clock, rising edge
//   d_reset_n      in   asynchronous active-low reset
//   enable_v_count in   end-of-line strobe, one line advance per high cycle
//   v_restart      in   synchronous frame restart (priority over enable)
//   v_count_value  out  current line, 0..V_TOTAL-1
//   v_region       out  0=ACTIVE 1=FRONT 2=SYNC 3=BACK
//   vsync          out  SYNC_POL while in SYNC, ~SYNC_POL otherwise
//   v_active       out  high while in ACTIVE
//   frame_start    out  one-cycle pulse when the count becomes 0
//   vblank_start   out  one-cycle pulse when the count becomes V_ACTIVE
//   frame_count    out  completed-frame counter, wraps modulo 2^FRAME_W
module vga_v_timing #(
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 16,
    parameter bit SYNC_POL = 1'b0,
    parameter int FRAME_W  = 8
) (
    input  logic               clk_25Mhz,
    input  logic               d_reset_n,
    input  logic               enable_v_count,
    input  logic               v_restart,
    output logic [CNT_W-1:0]   v_count_value,
    output logic [1:0]         v_region,
    output logic               vsync,
    output logic               v_active,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // First line of each region, and the last line of the frame.
    localparam logic [CNT_W-1:0] FRONT_LINE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LINE  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] BACK_LINE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } region_t;

    region_t             region, region_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [FRAME_W-1:0]  fc_nxt;
    logic                fs_nxt, vb_nxt, vsync_nxt, v_active_nxt;

    // Next-state logic: every output is derived from the next count/region
    // so the registered outputs never skew against v_count_value.
    always_comb begin
        cnt_nxt    = v_count_value;
        region_nxt = region;
        fc_nxt     = frame_count;
        fs_nxt     = 1'b0;
        vb_nxt     = 1'b0;

        if (v_restart) begin
            // Aborted frame: back to line 0 without counting a frame.
            cnt_nxt    = '0;
            region_nxt = ST_ACTIVE;
            fs_nxt     = 1'b1;
        end else if (enable_v_count) begin
            // ">=" also recovers any out-of-range count on the next strobe.
            if (v_count_value >= LAST_LINE) begin
                cnt_nxt = '0;
                fs_nxt  = 1'b1;
                fc_nxt  = frame_count + FRAME_W'(1);
            end else begin
                cnt_nxt = v_count_value + CNT_W'(1);
            end
            vb_nxt = (cnt_nxt == FRONT_LINE);

            case (region)
                ST_ACTIVE: if (cnt_nxt == FRONT_LINE) region_nxt = ST_FRONT;
                ST_FRONT:  if (cnt_nxt == SYNC_LINE)  region_nxt = ST_SYNC;
                ST_SYNC:   if (cnt_nxt == BACK_LINE)  region_nxt = ST_BACK;
                ST_BACK:   if (cnt_nxt == '0)         region_nxt = ST_ACTIVE;
                default:                              region_nxt = ST_ACTIVE;
            endcase
            // A wrap always lands in ACTIVE, whatever region we came from.
            if (cnt_nxt == '0) region_nxt = ST_ACTIVE;
        end

        vsync_nxt    = (region_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        v_active_nxt = (region_nxt == ST_ACTIVE);
    end

    // Output register stage.
    always_ff @(posedge clk_25Mhz or negedge d_reset_n) begin
        if (!d_reset_n) begin
            v_count_value <= '0;
            region        <= ST_ACTIVE;
            vsync         <= ~SYNC_POL;
            v_active      <= 1'b1;
            frame_start   <= 1'b0;
            vblank_start  <= 1'b0;
            frame_count   <= '0;
        end else begin
            v_count_value <= cnt_nxt;
            region        <= region_nxt;
            vsync         <= vsync_nxt;
            v_active      <= v_active_nxt;
            frame_start   <= fs_nxt;
            vblank_start  <= vb_nxt;
            frame_count   <= fc_nxt;
        end
    end

    assign v_region = region;

endmodule

// File: doc/vga_v_timing.md
Name: vga_v_timing

Overview:
Parametrised vertical timing generator, successor to the fixed 525-line vertical counter. It advances one line per end-of-line strobe from the horizontal counter and tracks the vertical region (active, front porch, sync, back porch) with an explicit state machine. It drives vsync with selectable polarity, a video-active flag, frame-start and vblank-start pulses, and a frame counter for the sprite/animation logic. It sits between the horizontal counter and the pixel/sprite renderer.

Parameters:
V_ACTIVE, 480, visible lines per frame (>=1)
V_FP, 10, front-porch lines (>=1)
V_SYNC, 2, sync-pulse lines (>=1)
V_BP, 33, back-porch lines (>=1)
CNT_W, 16, width of v_count_value; must hold V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
SYNC_POL, 0, vsync asserted level (0 = active-low, as in 640x480 VGA)
FRAME_W, 8, width of frame_count

Ports:
clk_25Mhz  input  1  pixel clock; all logic on its rising edge
d_reset_n  input  1  asynchronous active-low reset
enable_v_count  input  1  end-of-line strobe from the horizontal counter; one line advance per high cycle
v_restart  input  1  synchronous frame restart; forces line 0 on the next edge
v_count_value  output  CNT_W  current line, 0..V_TOTAL-1
v_region  output  2  0=ACTIVE, 1=FRONT, 2=SYNC, 3=BACK
vsync  output  1  sync pulse at SYNC_POL level while in SYNC
v_active  output  1  high while in ACTIVE
frame_start  output  1  one-cycle pulse on the cycle v_count_value becomes 0
vblank_start  output  1  one-cycle pulse on the cycle v_count_value becomes V_ACTIVE
frame_count  output  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

Behaviour:
- Reset (d_reset_n low, asynchronous): v_count_value=0, v_region=ACTIVE, v_active=1, vsync=~SYNC_POL, frame_start=0, vblank_start=0, frame_count=0. Release is synchronous to the next rising edge.
- All outputs are registered. Each output is computed from the next count value, so on every cycle region, vsync and v_active match v_count_value exactly. There is no skew between them.
- Line advance: when enable_v_count=1, the count becomes 0 if it is >= V_TOTAL-1; otherwise it increments by 1. When enable_v_count=0, all state holds and the pulses are 0.
- Out-of-range safety: a count >= V_TOTAL-1 always wraps to 0 on the next enable and never exceeds V_TOTAL-1.
- Region FSM, by line:
  - ACTIVE: 0..V_ACTIVE-1
  - FRONT: V_ACTIVE..V_ACTIVE+V_FP-1
  - SYNC: next V_SYNC lines
  - BACK: remaining lines to V_TOTAL-1
  - Transitions ACTIVE->FRONT->SYNC->BACK->ACTIVE happen only on an enabled advance at the region boundaries.
- vsync=SYNC_POL exactly while region=SYNC; otherwise ~SYNC_POL.
- v_active=1 exactly while region=ACTIVE.
- Wrap: on a wrap to 0, frame_start=1 for that single cycle and frame_count increments by 1 (modulo 2^FRAME_W).
- vblank_start=1 for the single cycle on which the count becomes V_ACTIVE.
- v_restart=1 has priority over enable_v_count:
  - next state is count=0, region=ACTIVE, vsync deasserted, v_active=1;
  - frame_start pulses; frame_count does NOT increment (the frame is aborted, not completed);
  - if v_restart=1 while the count is already 0, it still pulses frame_start.
- Pulses never last more than one cycle, even if enable_v_count is held high.
- Reset asserted mid-frame returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
1. Hold d_reset_n=0 mid-frame (count 300, region ACTIVE) -> outputs drop to reset values immediately: count 0, v_active=1, vsync=1 (SYNC_POL=0), frame_count=0.
2. Defaults, one enable strobe every 800 clocks for 525 strobes:
   - count runs 0..524 then wraps to 0;
   - vblank_start pulses at line 480;
   - vsync=0 only on lines 490-491;
   - v_region reads 1 over 480-489, 2 over 490-491, 3 over 492-524;
   - frame_start pulses once at the wrap; frame_count 0->1.
3. enable_v_count held high 256*525 cycles -> frame_count wraps 255->0; frame_start pulses are exactly 1 cycle wide, 525 cycles apart.
4. v_restart at line 491 (SYNC) with enable_v_count high in the same cycle -> next cycle: count 0, vsync=1, v_active=1, frame_start=1, frame_count unchanged.
5. Parameters V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, SYNC_POL=1, enable held high -> count cycles 0..7; vsync=1 only on line 5; v_active over lines 0-3.
6. Enable gaps (random 0-50 idle cycles between strobes) -> count and all outputs hold between strobes; there are no spurious pulses.
